// File: rtl/mux3_sel_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux3_pkg
//   Shared definitions for the 3:1 mux select arbiter: FSM state encoding,
//   mux select constants and small index helpers used by both the top level
//   and the round-robin picker.
//   No ports (package).
// ----------------------------------------------------------------------------
package mux3_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [1:0] SEL_D0 = 2'b00;
   localparam logic [1:0] SEL_D1 = 2'b01;
   localparam logic [1:0] SEL_D2 = 2'b10;

   // Pointer value after reset; makes source 0 the first in line.
   localparam logic [1:0] LAST_RESET = 2'd2;

   // Successor of a source index, modulo 3. The unused code 3 maps to 0 so
   // a corrupted index can never address outside the three sources.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      case (idx)
         2'd0:    return 2'd1;
         2'd1:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Mux select for a source index; 2'b11 is never produced.
   function automatic logic [1:0] sel_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return SEL_D0;
         2'd1:    return SEL_D1;
         default: return SEL_D2;
      endcase
   endfunction

   // One-hot grant vector for a source index.
   function automatic logic [2:0] onehot_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

endpackage

// File: rtl/mux3_sel_arbiter_rr_pick3.sv
// ----------------------------------------------------------------------------
// rr_pick3
//   Combinational round-robin picker for three requesters. Searches
//   last+1, last+2, last (mod 3) and returns the first asserted requester.
//   Ports:
//     req   in  [2:0]  request vector, req[i] for source i
//     last  in  [1:0]  index of the most recently granted source
//     idx   out [1:0]  chosen source index (valid only when found=1)
//     found out        at least one request is asserted
// ----------------------------------------------------------------------------
module rr_pick3
   import mux3_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] idx,
   output logic       found
);

   logic [1:0] first;
   logic [1:0] second;
   logic [1:0] third;

   // The third candidate is derived by stepping again rather than reusing
   // last directly, so it stays within 0..2 even if last were ever 3.
   assign first  = next_idx(last);
   assign second = next_idx(first);
   assign third  = next_idx(second);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      idx   = first;
      found = 1'b1;
      if (req[first]) begin
         idx = first;
      end else if (req[second]) begin
         idx = second;
      end else if (req[third]) begin
         idx = third;
      end else begin
         found = 1'b0;
      end
   end

endmodule

// File: rtl/mux3_sel_arbiter.sv
// ----------------------------------------------------------------------------
// mux3_sel_arbiter
//   Round-robin arbiter driving the select pair of a 3:1 data mux. A grant
//   lasts until the consumer pulses DONE, the granted source drops its
//   request, or HOLD_MAX cycles have elapsed. Every grant is followed by one
//   idle cycle so the mux select never switches directly between sources.
//   All outputs are registered.
//   Parameters:
//     HOLD_MAX  maximum consecutive cycles of one grant (1..15)
//     CW        hold counter width, at least clog2(HOLD_MAX+1)
//   Ports:
//     clk    in         rising-edge clock
//     rst_n  in         asynchronous active-low reset
//     REQ    in  [2:0]  request per source
//     DONE   in         consumer pulse releasing the current grant
//     S0     out        mux select bit 0
//     S1     out        mux select bit 1
//     GNT    out [2:0]  one-hot grant
//     VALID  out        high while a grant is active
// ----------------------------------------------------------------------------
module mux3_sel_arbiter
   import mux3_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int CW       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] REQ,
   input  logic       DONE,
   output logic       S0,
   output logic       S1,
   output logic [2:0] GNT,
   output logic       VALID
);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t          state;
   logic [1:0]      last;
   logic [1:0]      cur;
   logic [CW-1:0]   cnt;
   logic [2:0]      gnt_q;
   logic [1:0]      sel_q;
   logic            valid_q;

   logic [1:0]      pick_idx;
   logic            pick_found;
   logic            release_now;

   rr_pick3 u_pick (
      .req   (REQ),
      .last  (last),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Any of the three release causes; coincident causes are one release.
   assign release_now = DONE | ~REQ[cur] | (cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= LAST_RESET;
         cur     <= 2'd0;
         cnt     <= '0;
         gnt_q   <= 3'b000;
         sel_q   <= SEL_D0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (pick_found) begin
                  cur     <= pick_idx;
                  gnt_q   <= onehot_of(pick_idx);
                  sel_q   <= sel_of(pick_idx);
                  valid_q <= 1'b1;
                  cnt     <= '0;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  last    <= cur;
                  gnt_q   <= 3'b000;
                  sel_q   <= SEL_D0;
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end else if (cnt != CNT_MAX) begin
                  // Saturating; release at HOLD_LAST keeps this from wrapping.
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign GNT   = gnt_q;
   assign S0    = sel_q[0];
   assign S1    = sel_q[1];
   assign VALID = valid_q;

endmodule

// File: tb/tb_mux3_sel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux3_sel_arbiter
//   Self-checking bench for mux3_sel_arbiter. A cycle model pushes the
//   expected outputs into a queue at each rising edge; they are popped and
//   compared one time unit later. Scenario tasks add directed checks.
// ----------------------------------------------------------------------------
module tb_mux3_sel_arbiter;

   localparam int HOLD_MAX = 4;
   localparam int CW       = 4;
   localparam int WAIT_MAX = 2 * (HOLD_MAX + 1);

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] REQ   = 3'b000;
   logic       DONE  = 1'b0;
   logic       S0;
   logic       S1;
   logic [2:0] GNT;
   logic       VALID;

   always #5 clk = ~clk;

   mux3_sel_arbiter #(
      .HOLD_MAX (HOLD_MAX),
      .CW       (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .REQ   (REQ),
      .DONE  (DONE),
      .S0    (S0),
      .S1    (S1),
      .GNT   (GNT),
      .VALID (VALID)
   );

   // {gnt, sel, valid}
   typedef struct packed {
      logic [2:0] gnt;
      logic [1:0] sel;
      logic       valid;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   // Cycle model: m_held counts visible grant cycles (1..HOLD_MAX).
   logic m_busy;
   int   m_last;
   int   m_cur;
   int   m_held;
   int   wait_cnt [3];

   task automatic model_reset();
      m_busy = 1'b0;
      m_last = 2;
      m_cur  = 0;
      m_held = 0;
      sb_q.delete();
      for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
   endtask

   task automatic model_step();
      exp_t e;
      bit   got;
      if (!m_busy) begin
         got = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (!got && REQ[c]) begin
               got    = 1'b1;
               m_cur  = c;
               m_held = 1;
               m_busy = 1'b1;
            end
         end
      end else if (DONE || !REQ[m_cur] || m_held == HOLD_MAX) begin
         m_last = m_cur;
         m_busy = 1'b0;
      end else begin
         m_held++;
      end
      e.gnt   = m_busy ? (3'b001 << m_cur) : 3'b000;
      e.sel   = m_busy ? 2'(m_cur) : 2'b00;
      e.valid = m_busy;
      sb_q.push_back(e);
   endtask

   // One clock: model update at the edge, compare 1 time unit later.
   task automatic cycle(input string tag);
      exp_t       e;
      exp_t       got;
      logic [1:0] gsel;
      @(posedge clk);
      model_step();
      #1;
      got = {GNT, S1, S0, VALID};
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_mis++;
         $display("FAIL %s_sb: scoreboard empty, got gnt=%b sel=%b%b valid=%b", tag, GNT, S1, S0, VALID);
      end else begin
         e = sb_q.pop_front();
         if (got !== e) begin
            n_mis++;
            $display("FAIL %s_sb @%0t: got gnt=%b sel=%b valid=%b, expected gnt=%b sel=%b valid=%b",
                     tag, $time, got.gnt, got.sel, got.valid, e.gnt, e.sel, e.valid);
         end
      end
      n_cmp++;
      if (!$onehot0(GNT)) begin
         n_mis++;
         $display("FAIL %s_onehot @%0t: got gnt=%b, expected zero or one-hot", tag, $time, GNT);
      end
      n_cmp++;
      if (VALID !== (|GNT)) begin
         n_mis++;
         $display("FAIL %s_valid @%0t: got valid=%b, expected |gnt=%b", tag, $time, VALID, |GNT);
      end
      case (GNT)
         3'b010:  gsel = 2'b01;
         3'b100:  gsel = 2'b10;
         default: gsel = 2'b00;
      endcase
      n_cmp++;
      if ({S1, S0} !== gsel) begin
         n_mis++;
         $display("FAIL %s_sel @%0t: got sel=%b%b for gnt=%b, expected %b", tag, $time, S1, S0, GNT, gsel);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      REQ   = 3'b000;
      DONE  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b000_00_0) begin
         n_mis++;
         $display("FAIL reset_values: got gnt=%b sel=%b%b valid=%b, expected 000/00/0", GNT, S1, S0, VALID);
      end
      do_reset();
      cycle("reset_idle");
   endtask

   task automatic test_single();
      do_reset();
      REQ = 3'b001;
      cycle("single_grant");
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b001_00_1) begin
         n_mis++;
         $display("FAIL single_grant: got gnt=%b sel=%b%b valid=%b, expected 001/00/1", GNT, S1, S0, VALID);
      end
      cycle("single_hold");
      cycle("single_hold");
      DONE = 1'b1;
      cycle("single_done");
      n_cmp++;
      if ({GNT, VALID} !== 4'b000_0) begin
         n_mis++;
         $display("FAIL single_done: got gnt=%b valid=%b, expected 000/0", GNT, VALID);
      end
      DONE = 1'b0;
      REQ  = 3'b000;
      cycle("single_idle");
   endtask

   task automatic test_round_robin();
      logic [2:0] want_g;
      logic [1:0] want_s;
      do_reset();
      REQ = 3'b111;
      for (int k = 0; k < 16; k++) begin
         cycle("rr");
         want_g = (k % 5 == 4) ? 3'b000 : (3'b001 << ((k / 5) % 3));
         want_s = (k % 5 == 4) ? 2'b00 : 2'((k / 5) % 3);
         n_cmp++;
         if (GNT !== want_g || {S1, S0} !== want_s) begin
            n_mis++;
            $display("FAIL rr_order cycle %0d: got gnt=%b sel=%b%b, expected gnt=%b sel=%b",
                     k, GNT, S1, S0, want_g, want_s);
         end
      end
      REQ = 3'b000;
      cycle("rr_end");
      cycle("rr_end");
   endtask

   task automatic test_drop();
      do_reset();
      REQ = 3'b010;
      cycle("drop_grant");
      cycle("drop_grant");
      REQ = 3'b000;
      cycle("drop_release");
      n_cmp++;
      if ({GNT, VALID} !== 4'b000_0) begin
         n_mis++;
         $display("FAIL drop_release: got gnt=%b valid=%b, expected 000/0", GNT, VALID);
      end
      REQ = 3'b111;
      cycle("drop_next");
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b100_10_1) begin
         n_mis++;
         $display("FAIL drop_next: got gnt=%b sel=%b%b valid=%b, expected 100/10/1", GNT, S1, S0, VALID);
      end
      DONE = 1'b1;
      REQ  = 3'b000;
      cycle("drop_end");
      DONE = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      REQ = 3'b100;
      repeat (4) cycle("sim_hold");
      DONE = 1'b1;
      cycle("sim_release");
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b000_00_0) begin
         n_mis++;
         $display("FAIL sim_release: got gnt=%b sel=%b%b valid=%b, expected 000/00/0", GNT, S1, S0, VALID);
      end
      DONE = 1'b0;
      cycle("sim_regrant");
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b100_10_1) begin
         n_mis++;
         $display("FAIL sim_regrant: got gnt=%b sel=%b%b valid=%b, expected 100/10/1", GNT, S1, S0, VALID);
      end
      REQ = 3'b000;
      cycle("sim_end");
   endtask

   task automatic test_async_reset();
      do_reset();
      REQ = 3'b100;
      cycle("ar_grant");
      n_cmp++;
      if (GNT !== 3'b100) begin
         n_mis++;
         $display("FAIL ar_grant: got gnt=%b, expected 100", GNT);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b000_00_0) begin
         n_mis++;
         $display("FAIL ar_async: got gnt=%b sel=%b%b valid=%b, expected 000/00/0", GNT, S1, S0, VALID);
      end
      model_reset();
      REQ = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("ar_first");
      n_cmp++;
      if ({GNT, S1, S0, VALID} !== 6'b001_00_1) begin
         n_mis++;
         $display("FAIL ar_first: got gnt=%b sel=%b%b valid=%b, expected 001/00/1", GNT, S1, S0, VALID);
      end
      REQ = 3'b000;
      cycle("ar_end");
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 3) == 0) REQ = 3'($urandom_range(0, 7));
         DONE = ($urandom_range(0, 7) == 0);
         cycle("rand");
         // Time a held request spends behind other sources' grants.
         for (int i = 0; i < 3; i++) begin
            if (!REQ[i] || GNT[i]) wait_cnt[i] = 0;
            else if (VALID) wait_cnt[i]++;
            n_cmp++;
            if (wait_cnt[i] > WAIT_MAX) begin
               n_mis++;
               $display("FAIL rand_starve src %0d: waited %0d cycles, expected at most %0d",
                        i, wait_cnt[i], WAIT_MAX);
               wait_cnt[i] = 0;
            end
         end
      end
      REQ  = 3'b000;
      DONE = 1'b0;
      cycle("rand_end");
      cycle("rand_end");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
